// File: rtl/sap_mem.sv
// -----------------------------------------------------------------------------
// sap_mem : SAP-3 program/data memory stage with boot loader
//
// Purpose
//   Byte-wide RAM addressed through a memory address register (MAR). The CPU
//   loads the MAR and writes RAM in RUN. In BOOT, a valid/ready byte stream
//   fills the RAM from address 0, and the CPU is held in reset.
//   The read port is combinational. The CPU bus mux samples mem_out in the
//   same cycle it enables it.
//
// Optional feature (macro SAP_MEM_WP_EN)
//   When defined, RUN-mode writes below WP_LIMIT are suppressed and flagged on
//   the sticky o_wp_fault. When undefined, all RUN writes proceed and
//   o_wp_fault stays 0.
//
// Ports
//   clk           system clock (shared with the CPU)
//   rst_n         asynchronous active-low reset
//   i_mar_we      load MAR from i_bus[ADDR_W-1:0]           (RUN only)
//   i_ram_we      write i_bus[7:0] to RAM[MAR]              (RUN only)
//   i_bus         16-bit CPU bus
//   o_mem_out     RAM[MAR], combinational
//   i_load_start  pulse: leave RUN and re-enter BOOT
//   i_load_valid  loader byte valid
//   i_load_data   loader byte
//   i_load_last   final byte of the image (qualified by i_load_valid)
//   o_load_ready  loader may transfer (BOOT)
//   o_cpu_hold    active-high reset request to the CPU (BOOT)
//   o_load_count  bytes accepted in the current/last load
//   o_wp_fault    sticky write-protect violation
// -----------------------------------------------------------------------------
module sap_mem #(
  parameter int         ADDR_W   = 8,
  parameter logic [7:0] WP_LIMIT = 8'h40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mar_we,
  input  logic              i_ram_we,
  input  logic [15:0]       i_bus,
  output logic [7:0]        o_mem_out,
  input  logic              i_load_start,
  input  logic              i_load_valid,
  input  logic [7:0]        i_load_data,
  input  logic              i_load_last,
  output logic              o_load_ready,
  output logic              o_cpu_hold,
  output logic [ADDR_W:0]   o_load_count,
  output logic              o_wp_fault
);

  localparam int                DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_MAX = '1;
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE = 1;

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_mar;
  logic [ADDR_W-1:0] r_load_ptr;
  logic [ADDR_W:0]   r_load_count;
  logic              r_wp_fault;
  logic [7:0]        r_ram [DEPTH];

  logic              w_boot;
  logic              w_xfer;
  logic              w_run_cmd;
  logic              w_below_limit;
  logic              w_wp_block;
  logic              w_run_wr;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [7:0]        w_ram_din;

  assign w_boot = (r_state == S_BOOT);
  // A transfer needs only valid: ready is simply "in BOOT".
  assign w_xfer = w_boot & i_load_valid;
  // CPU commands act only in RUN, and a load_start pre-empts them.
  assign w_run_cmd = ~w_boot & ~i_load_start;
  assign w_below_limit = (16'(r_mar) < 16'(WP_LIMIT));

`ifdef SAP_MEM_WP_EN
  assign w_wp_block = i_ram_we & w_run_cmd & w_below_limit;
`else
  assign w_wp_block = 1'b0;
  logic w_unused_wp;
  assign w_unused_wp = w_below_limit;
`endif

  // Only bus[7:0] (data) and bus[ADDR_W-1:0] (address) matter. The rest of the bus is ignored.
  logic w_unused_bus;
  assign w_unused_bus = ^i_bus;

  assign w_run_wr = i_ram_we & w_run_cmd & ~w_wp_block;

  // Single RAM write port, shared by the loader (BOOT) and the CPU (RUN).
  always_comb begin
    w_ram_we   = w_xfer | w_run_wr;
    w_ram_addr = w_boot ? r_load_ptr : r_mar;
    w_ram_din  = w_boot ? i_load_data : i_bus[7:0];
  end

  // Reset does not clear the RAM contents, so this port has no reset.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_ram[w_ram_addr] <= w_ram_din;
    end
  end

  // Zero-latency read. A write shows up once the MAR'd word has been updated.
  assign o_mem_out = r_ram[r_mar];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_BOOT;
      r_mar        <= '0;
      r_load_ptr   <= '0;
      r_load_count <= '0;
      r_wp_fault   <= 1'b0;
    end else begin
      case (r_state)
        S_BOOT: begin
          // MAR is parked at 0 so the CPU's first fetch after BOOT starts at 0.
          r_mar <= '0;
          if (i_load_valid) begin
            r_load_count <= {1'b0, r_load_ptr} + CNT_ONE;
            // Saturate the pointer. A transfer at the top address always exits BOOT.
            if (r_load_ptr != PTR_MAX) begin
              r_load_ptr <= r_load_ptr + PTR_ONE;
            end
            if (i_load_last || (r_load_ptr == PTR_MAX)) begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (i_load_start) begin
            r_state      <= S_BOOT;
            r_mar        <= '0;
            r_load_ptr   <= '0;
            r_load_count <= '0;
            r_wp_fault   <= 1'b0;
          end else begin
            // A concurrent ram_we has already used the old MAR through w_ram_addr.
            if (i_mar_we) begin
              r_mar <= i_bus[ADDR_W-1:0];
            end
            if (w_wp_block) begin
              r_wp_fault <= 1'b1;
            end
          end
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

  // Decoded from the state register alone, so both outputs are glitch-free.
  assign o_load_ready = w_boot;
  assign o_cpu_hold   = w_boot;
  assign o_load_count = r_load_count;
  assign o_wp_fault   = r_wp_fault;

endmodule

// File: tb/tb_sap_mem.sv
`timescale 1ns/1ps
module tb_sap_mem;

  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;
`ifdef SAP_MEM_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mar_we = 1'b0, ram_we = 1'b0, load_start = 1'b0;
  logic        load_valid = 1'b0, load_last = 1'b0;
  logic [15:0] bus = '0;
  logic [7:0]  load_data = '0;
  logic [7:0]  mem_out;
  logic        load_ready, cpu_hold, wp_fault;
  logic [AW:0] load_count;

  always #5 clk = ~clk;

  sap_mem #(.ADDR_W(AW), .WP_LIMIT(8'h40)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_mar_we     (mar_we),
    .i_ram_we     (ram_we),
    .i_bus        (bus),
    .o_mem_out    (mem_out),
    .i_load_start (load_start),
    .i_load_valid (load_valid),
    .i_load_data  (load_data),
    .i_load_last  (load_last),
    .o_load_ready (load_ready),
    .o_cpu_hold   (cpu_hold),
    .o_load_count (load_count),
    .o_wp_fault   (wp_fault)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: memory image plus a few scalars. A value of -1 means unknown.
  bit m_boot;
  int m_ptr, m_count, m_mar;
  bit m_fault;
  int m_ram [DEPTH];

  typedef struct {
    logic        mar_we, ram_we, load_start, load_valid;
    logic [15:0] bus;
    logic [7:0]  load_data;
    logic        chk_mem;
    logic [7:0]  exp_mem;
    logic        exp_hold;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(logic mw, logic rw, logic ls, logic lv, logic [15:0] b,
                              logic [7:0] ld, logic cm, logic [7:0] em, logic eh);
    vec_t v;
    v.mar_we = mw; v.ram_we = rw; v.load_start = ls; v.load_valid = lv;
    v.bus = b; v.load_data = ld; v.chk_mem = cm; v.exp_mem = em; v.exp_hold = eh;
    return v;
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_boot = 1'b1; m_ptr = 0; m_count = 0; m_mar = 0; m_fault = 1'b0;
  endfunction

  // Apply the behavioural rules to the inputs present at the clock edge.
  function automatic void model_edge();
    if (m_boot) begin
      if (load_valid) begin
        m_ram[m_ptr] = int'(load_data);
        m_count = m_ptr + 1;
        if (load_last || m_ptr == DEPTH - 1) m_boot = 1'b0;
        if (m_ptr < DEPTH - 1) m_ptr++;
      end
    end else if (load_start) begin
      m_boot = 1'b1; m_ptr = 0; m_count = 0; m_mar = 0; m_fault = 1'b0;
    end else begin
      if (ram_we) begin
        if (WP && m_mar < 'h40) m_fault = 1'b1;
        else m_ram[m_mar] = int'(bus[7:0]);
      end
      if (mar_we) m_mar = int'(bus[AW-1:0]);
    end
  endfunction

  task automatic check_model(string tag);
    check({tag, ".ready"}, 32'(load_ready), 32'(m_boot));
    check({tag, ".hold"},  32'(cpu_hold),   32'(m_boot));
    check({tag, ".count"}, 32'(load_count), 32'(m_count));
    check({tag, ".fault"}, 32'(wp_fault),   32'(m_fault));
    if (m_ram[m_mar] >= 0) check({tag, ".mem_out"}, 32'(mem_out), 32'(m_ram[m_mar]));
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic drive(logic mw, logic rw, logic ls, logic lv, logic [15:0] b,
                       logic [7:0] ld, logic ll);
    mar_we = mw; ram_we = rw; load_start = ls; load_valid = lv;
    bus = b; load_data = ld; load_last = ll;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
  endtask

  task automatic load_byte(logic [7:0] d, logic last, string tag);
    check({tag, ".ready_before"}, 32'(load_ready), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, d, last);
    tick(tag);
    $display("load %s data=%02h last=%0b count=%0d hold=%0b", tag, d, last, load_count, cpu_hold);
  endtask

  task automatic set_mar(logic [15:0] a, string tag);
    drive(1'b1, 1'b0, 1'b0, 1'b0, a, 8'h00, 1'b0);
    tick(tag);
    $display("mar  %s bus=%04h mem_out=%02h", tag, a, mem_out);
  endtask

  task automatic write_ram(logic [15:0] b, string tag);
    drive(1'b0, 1'b1, 1'b0, 1'b0, b, 8'h00, 1'b0);
    tick(tag);
    $display("wr   %s bus=%04h mem_out=%02h fault=%0b", tag, b, mem_out, wp_fault);
  endtask

  task automatic async_reset(string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_model(tag);
    check({tag, ".count_zero"}, 32'(load_count), 32'd0);
    #2 rst_n = 1'b1;
    $display("rst  %s ready=%0b count=%0d", tag, load_ready, load_count);
  endtask

  initial begin
    logic [7:0] first_fill;
    logic [7:0] b8;
    for (int i = 0; i < DEPTH; i++) m_ram[i] = -1;
    model_reset();

    // Test 1: reset, then a three-byte image.
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    check("reset.ready", 32'(load_ready), 32'd1);
    rst_n = 1'b1;
    load_byte(8'h3E, 1'b0, "t1.b0");
    load_byte(8'h05, 1'b0, "t1.b1");
    check("t1.hold_mid", 32'(cpu_hold), 32'd1);
    load_byte(8'h76, 1'b1, "t1.b2");
    idle();
    check("t1.hold_run", 32'(cpu_hold), 32'd0);
    check("t1.count", 32'(load_count), 32'd3);
    check("t1.ram0", 32'(mem_out), 32'h3E);
    set_mar(16'h0001, "t1.rd1");
    check("t1.ram1", 32'(mem_out), 32'h05);
    set_mar(16'h0002, "t1.rd2");
    check("t1.ram2", 32'(mem_out), 32'h76);
    set_mar(16'h0000, "t1.rd0");

    // Table of RUN-mode vectors. All written addresses are >= 0x40, so the table is the same for both builds.
    tbl[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'hAB52, 8'h00, 1'b0, 8'h00, 1'b0);
    tbl[1] = mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0055, 8'h00, 1'b1, 8'h55, 1'b0);
    tbl[2] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0060, 8'h00, 1'b0, 8'h00, 1'b0);
    tbl[3] = mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0052, 8'h00, 1'b1, 8'h55, 1'b0);
    tbl[4] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0060, 8'h00, 1'b1, 8'h52, 1'b0);
    tbl[5] = mk(1'b0, 1'b1, 1'b0, 1'b0, 16'hFF77, 8'h00, 1'b1, 8'h77, 1'b0);
    tbl[6] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h3E, 1'b0);
    tbl[7] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0102, 8'h00, 1'b1, 8'h76, 1'b0);
    tbl[8] = mk(1'b1, 1'b0, 1'b0, 1'b1, 16'h0060, 8'hAA, 1'b1, 8'h77, 1'b0);
    tbl[9] = mk(1'b0, 1'b1, 1'b1, 1'b0, 16'h0011, 8'h00, 1'b1, 8'h3E, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].mar_we, tbl[i].ram_we, tbl[i].load_start, tbl[i].load_valid,
            tbl[i].bus, tbl[i].load_data, 1'b0);
      tick($sformatf("tbl%0d", i));
      if (tbl[i].chk_mem) check($sformatf("tbl%0d.mem", i), 32'(mem_out), 32'(tbl[i].exp_mem));
      check($sformatf("tbl%0d.hold", i), 32'(cpu_hold), 32'(tbl[i].exp_hold));
      $display("vec  %0d bus=%04h mem_out=%02h hold=%0b", i, tbl[i].bus, mem_out, cpu_hold);
    end
    check("tbl.count_cleared", 32'(load_count), 32'd0);

    // Test 2: throttled loader. The CPU strobes toggle as well and must be ignored in BOOT.
    for (int i = 0; i < 7; i++) begin
      b8 = 8'(8'h11 * (i / 2 + 1));
      drive(1'b1, 1'b1, 1'b0, (i % 2 == 0), 16'($urandom),
            (i % 2 == 0) ? b8 : 8'hEE, (i == 6));
      tick($sformatf("t2.c%0d", i));
      $display("load t2.c%0d valid=%0b count=%0d", i, (i % 2 == 0), load_count);
    end
    idle();
    check("t2.hold", 32'(cpu_hold), 32'd0);
    check("t2.count", 32'(load_count), 32'd4);
    check("t2.ram0", 32'(mem_out), 32'h11);
    for (int a = 1; a < 4; a++) begin
      set_mar(16'(a), $sformatf("t2.rd%0d", a));
      check($sformatf("t2.ram%0d", a), 32'(mem_out), 32'(8'h11 * (a + 1)));
    end
    set_mar(16'h0060, "t2.rd60");
    check("t2.dropped_write", 32'(mem_out), 32'h77);

    // Tests 3/4: bus upper byte ignored, and a simultaneous MAR load and write.
    set_mar(16'hAB12, "t3.mar");
    write_ram(16'h0055, "t3.wr");
    set_mar(16'h0020, "t4.mar20");
    write_ram(16'h00C3, "t4.wr20");
    set_mar(16'h0010, "t4.mar10");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0020, 8'h00, 1'b0);
    tick("t4.both");
    $display("both t4 mem_out=%02h", mem_out);
    set_mar(16'h0010, "t4.rd10");
`ifndef SAP_MEM_WP_EN
    check("t4.ram10", 32'(mem_out), 32'h20);
    set_mar(16'h0012, "t3.rd12");
    check("t3.ram12", 32'(mem_out), 32'h55);
`endif

`ifdef SAP_MEM_WP_EN
    // Test 6: write protection.
    set_mar(16'h0001, "t6.mar01");
    write_ram(16'h00FF, "t6.wr01");
    check("t6.fault", 32'(wp_fault), 32'd1);
    check("t6.unchanged", 32'(mem_out), 32'h22);
    set_mar(16'h0050, "t6.mar50");
    write_ram(16'h0066, "t6.wr50");
    check("t6.wr50_ok", 32'(mem_out), 32'h66);
    check("t6.fault_sticky", 32'(wp_fault), 32'd1);
`endif

    // Re-enter BOOT, then reset partway through a load.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
    tick("rl.start");
    check("rl.hold", 32'(cpu_hold), 32'd1);
    check("rl.fault_clr", 32'(wp_fault), 32'd0);
    load_byte(8'hA1, 1'b0, "rl.b0");
    load_byte(8'hA2, 1'b0, "rl.b1");
    idle();
    async_reset("rl.rst");
    load_byte(8'hB0, 1'b1, "rl.b2");
    idle();
    check("rl.count", 32'(load_count), 32'd1);
    check("rl.ram0", 32'(mem_out), 32'hB0);
    set_mar(16'h0001, "rl.rd1");
    check("rl.kept", 32'(mem_out), 32'hA2);

    // Test 5: fill the whole memory without load_last.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
    tick("t5.start");
    first_fill = 8'($urandom);
    for (int i = 0; i < DEPTH; i++) begin
      b8 = (i == 0) ? first_fill : 8'($urandom);
      if (i == DEPTH - 1) check("t5.hold_before_last", 32'(cpu_hold), 32'd1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, b8, 1'b0);
      tick($sformatf("t5.b%0d", i));
      $display("load t5.b%0d data=%02h count=%0d", i, b8, load_count);
    end
    idle();
    check("t5.hold", 32'(cpu_hold), 32'd0);
    check("t5.count", 32'(load_count), 32'(DEPTH));
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h5A, 1'b1);
    tick("t5.extra");
    check("t5.extra_count", 32'(load_count), 32'(DEPTH));
    check("t5.extra_ram0", 32'(mem_out), 32'(first_fill));
    $display("load t5.extra ready=%0b count=%0d", load_ready, load_count);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 7),
            16'($urandom), 8'($urandom), ($urandom_range(0, 19) == 0));
      tick($sformatf("rnd%0d", i));
      $display("rnd  %0d mw=%0b rw=%0b ls=%0b lv=%0b bus=%04h mem_out=%02h hold=%0b cnt=%0d",
               i, mar_we, ram_we, load_start, load_valid, bus, mem_out, cpu_hold, load_count);
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sap_mem.md
Name: sap_mem

Overview:
- Program/data memory stage directly downstream of the SAP-3 CPU core.
- Consumes the CPU's `mem_mar_we`, `mem_ram_we` and 16-bit bus; returns `mem_out` for the CPU bus mux.
- Contains a boot-loader FSM. It fills RAM from a byte-wide valid/ready stream and holds the CPU in reset (`cpu_hold`) until loading completes.

Parameters:
- ADDR_W, 8, MAR width; RAM depth = 2**ADDR_W bytes.
- WP_LIMIT, 8'h40, first writable address when write protection is compiled in.

Ports:
- clk  in  1  system clock (same clock as CPU `clk`).
- rst_n  in  1  asynchronous active-low reset.
- mar_we  in  1  load MAR from bus (CPU `mem_mar_we`).
- ram_we  in  1  write bus[7:0] to RAM[MAR] (CPU `mem_ram_we`).
- bus  in  16  CPU bus.
- mem_out  out  8  RAM[MAR], combinational read.
- load_start  in  1  pulse: re-enter BOOT from RUN.
- load_valid  in  1  loader byte valid.
- load_data  in  8  loader byte.
- load_last  in  1  marks final byte; qualified by load_valid.
- load_ready  out  1  loader may transfer.
- cpu_hold  out  1  active-high reset request to the CPU.
- load_count  out  ADDR_W+1  bytes accepted in current/last load.
- wp_fault  out  1  sticky write-protect violation flag.

Behaviour:
- States: BOOT, RUN. The state is registered.
- Reset (rst_n=0, asynchronous):
  - state=BOOT, MAR=0, load_ptr=0, load_count=0, wp_fault=0.
  - RAM contents are not cleared.
- Outputs by state:
  - load_ready = (state==BOOT).
  - cpu_hold = (state==BOOT). Both are decoded from the state register only, so they are glitch-free.
- BOOT:
  - A transfer occurs on a clock edge with load_valid && load_ready. It writes RAM[load_ptr]=load_data, increments load_ptr, and sets load_count = load_ptr+1.
  - Transfer with load_last=1 → RUN at the next edge.
  - Transfer at load_ptr == 2**ADDR_W-1 → RUN regardless of load_last. The memory is full and load_ptr does not wrap.
  - mar_we and ram_we are ignored in BOOT.
  - MAR is held at 0.
- RUN:
  - mar_we: MAR <= bus[ADDR_W-1:0]; upper bus bits are ignored.
  - ram_we: RAM[MAR] <= bus[7:0] at the edge.
  - mar_we and ram_we in the same cycle: the write uses the old MAR, and MAR updates at the same edge.
  - Loader inputs are ignored.
  - load_start=1 → BOOT at the next edge, with load_ptr=0, load_count=0 and MAR=0. It wins over a simultaneous mar_we/ram_we; the write is dropped.
- mem_out = RAM[MAR], combinational (zero latency).
  - Required by the CPU bus mux: `mem_oe` and the bus capture happen in the same cycle.
  - A write to RAM[MAR] is visible on mem_out in the cycle after the write edge.
- The first RUN cycle has cpu_hold=0. The CPU's first instruction fetch sees MAR=0.
- Reset mid-load: the partially loaded RAM is kept, state returns to BOOT, and load_ptr returns to 0.

Optional Feature:
- Macro: SAP_MEM_WP_EN.
- Defined:
  - RUN-mode ram_we with MAR < WP_LIMIT is suppressed (RAM unchanged).
  - wp_fault sets at that edge and stays set until reset or until load_start re-enters BOOT.
  - Boot-loader writes are never protected.
- Undefined:
  - All RUN writes proceed.
  - wp_fault is tied to 0.
  - WP_LIMIT is unused.

Test Plan:
1. Reset, then stream 0x3E, 0x05, 0x76 with load_last on the third byte.
   - load_ready=1 throughout.
   - RUN entered one edge after the third byte; cpu_hold falls.
   - load_count=3; RAM[0..2]=3E,05,76.
2. Throttled loader: load_valid toggles every other cycle for 4 bytes.
   - Only valid cycles write.
   - load_count=4; no bytes are skipped or duplicated.
3. RUN: bus=16'hAB12 with mar_we, then bus=16'h0055 with ram_we.
   - MAR=0x12.
   - mem_out=0x55 the cycle after the write edge.
   - Upper byte 0xAB is ignored.
4. Simultaneous mar_we+ram_we with MAR=0x10 and bus=16'h0020.
   - RAM[0x10]=0x20.
   - MAR=0x20 afterwards.
5. Fill test (ADDR_W=4): 16 bytes with no load_last.
   - RUN after the 16th byte; load_count=16.
   - A 17th load_valid is not accepted.
6. SAP_MEM_WP_EN defined: RUN write to 0x10 (< 0x40).
   - RAM unchanged; wp_fault=1.
   - Write to 0x50 succeeds.
   - load_start clears wp_fault and reasserts cpu_hold.
   - A rst_n pulse mid-load returns to BOOT with load_count=0.
